dmem_responder: RTL

Data-memory responder for the RV32I core's load/store port: the target end of the core's data-memory interface (address, store data, 3-bit RISC-V width/sign op, write enable). It holds a word-organised RAM. Each request is handled by a small FSM that checks alignment, inserts a configurable number of wait states, performs byte-lane-masked writes or sign/zero-extended reads, and returns a one-cycle `ready` pulse. It serves the multi-cycle core variants and the memory-system benches.

---
 rtl/dmem_responder_if.sv | 14 +
 rtl/dmem_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bundle between the core and the data RAM
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  op;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;
   modport master (output req, we, addr, wdata, op, input rdata, ready, err, busy);
   modport slave  (input req, we, addr, wdata, op, output rdata, ready, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM target for the RV32I load/store port with wait states and lane-masked access
module dmem_responder #(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_CYCLES = 0
) (
   input logic            clock,
   input logic            reset,
   dmem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  we_q, we_d, bad_q, bad_d;
   logic                  ready_q, ready_d, err_q, err_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
   logic [2:0]            op_q, op_d;
   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           word, lanes, ext;
   logic [15:0]           half_v;
   logic [7:0]            byte_v;
   logic [3:0]            be;
   logic                  illegal, misaligned, wr_en, unused_addr;
   assign illegal    = bus.op == 3'b011 || bus.op[2:1] == 2'b11 || (bus.we && bus.op[2]);
   assign misaligned = (bus.op[1:0] == 2'b01 && bus.addr[0]) ||
                       (bus.op[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
   assign unused_addr = ^bus.addr[31:ADDR_WIDTH+2];
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         bad_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         bad_q   <= bad_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      bad_d   = bad_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      case (state_q)
         IDLE: if (bus.req) begin
            we_d    = bus.we;
            addr_d  = bus.addr[ADDR_WIDTH+1:0];
            wdata_d = bus.wdata;
            op_d    = bus.op;
            bad_d   = illegal || misaligned;
            cnt_d   = WAIT_CYCLES > 0 ? 8'(WAIT_CYCLES - 1) : 8'd0;
            state_d = (illegal || misaligned) ? RESP : (WAIT_CYCLES > 0 ? WAIT : ACCESS);
         end
         WAIT: begin
            cnt_d   = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
            state_d = cnt_q == 8'd0 ? ACCESS : WAIT;
         end
         ACCESS: state_d = RESP;
         default: state_d = IDLE;
      endcase
   end
   // Response flags lag RESP by one edge, so ready/err/rdata are all plain flops.
   always_comb begin
      idx     = addr_q[ADDR_WIDTH+1:2];
      word    = mem[idx];
      byte_v  = word[{addr_q[1:0], 3'b000} +: 8];
      half_v  = addr_q[1] ? word[31:16] : word[15:0];
      ext     = op_q[1] ? word :
                op_q[0] ? {{16{~op_q[2] & half_v[15]}}, half_v} :
                          {{24{~op_q[2] & byte_v[7]}}, byte_v};
      be      = op_q[1] ? 4'b1111 : op_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
      lanes   = op_q[1] ? wdata_q : op_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
      wr_en   = state_q == ACCESS && we_q;
      ready_d = state_q == RESP;
      err_d   = state_q == RESP && bad_q;
      rdata_d = (state_q == ACCESS && !we_q) ? ext : (state_q == IDLE ? '0 : rdata_q);
   end
   always_ff @(posedge clock)
      for (int i = 0; i < 4; i++)
         if (wr_en && be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
   assign bus.ready = ready_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = state_q != IDLE;
endmodule
